fetch_pc_unit: RTL and testbench

//  Fetch-stage next-PC generator sitting directly upstream of branch_predictor: drives f_pc,

---
 rtl/fetch_pc_if.sv | 32 +++
 rtl/fetch_pc_unit.sv | 129 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_if.sv
// Bundle between the fetch next-PC unit and its neighbours (predictor, DECODE, EXEC).
// Qualifiers: the d_* fields are meaningful only while d_is_branch=1, and the x_* fields only while x_resolve_valid=1. There is no back-pressure on either; the unit reports a full queue through fetch_stall and a bad resolve through q_error.
interface fetch_pc_if;
  logic        stall;
  logic [31:0] f_predict_addr;
  logic        f_predict_valid;
  logic        d_is_branch;
  logic [31:0] d_pc;
  logic [31:0] d_target_addr;
  logic        x_resolve_valid;
  logic        x_taken;
  logic [31:0] x_target;
  logic [31:0] f_pc;
  logic        f_kill;
  logic        d_pred_taken;
  logic        fetch_stall;
  logic        flush;
  logic [15:0] mispredict_cnt;
  logic        q_error;

  modport master (
    output stall, f_predict_addr, f_predict_valid, d_is_branch, d_pc, d_target_addr,
           x_resolve_valid, x_taken, x_target,
    input  f_pc, f_kill, d_pred_taken, fetch_stall, flush, mispredict_cnt, q_error
  );

  modport slave (
    input  stall, f_predict_addr, f_predict_valid, d_is_branch, d_pc, d_target_addr,
           x_resolve_valid, x_taken, x_target,
    output f_pc, f_kill, d_pred_taken, fetch_stall, flush, mispredict_cnt, q_error
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage next-PC generator: follows predictor hits, queues in-flight branches,
// and redirects/flushes the front end when EXEC reports a mispredict.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic      clk,
  input  logic      reset,
  fetch_pc_if.slave bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
  localparam logic [CW-1:0] HIGH_CNT = CW'(QDEPTH - 1);

  logic          q_pred [QDEPTH];
  logic [31:0]   q_tgt  [QDEPTH];
  logic [31:0]   q_ft   [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;

  logic [31:0] pc_q;
  logic        look_q;
  logic        pend_v;
  logic [31:0] pend_a;
  logic        dpt_q;
  logic        fstall_q;
  logic [15:0] miss_cnt_q;
  logic        err_q;

  logic        q_empty, q_full, pop, push_req, push, mispredict;
  logic        head_pred;
  logic [31:0] head_tgt, head_ft, redirect_addr;
  logic        hit_now, hit, fetch_hold;
  logic [31:0] hit_addr;

  assign q_empty    = (count == '0);
  assign q_full     = (count == FULL_CNT);
  assign head_pred  = q_pred[rd_ptr];
  assign head_tgt   = q_tgt[rd_ptr];
  assign head_ft    = q_ft[rd_ptr];
  assign pop        = bus.x_resolve_valid & ~q_empty;
  assign mispredict = pop & ((bus.x_taken != head_pred) |
                             (bus.x_taken & (bus.x_target != head_tgt)));
  assign redirect_addr = bus.x_taken ? bus.x_target : head_ft;
  assign push_req   = bus.d_is_branch & ~bus.stall & ~mispredict;
  assign push       = push_req & (~q_full | pop);

  always_comb begin
    count_nxt = count;
    if (mispredict) count_nxt = '0;
    else            count_nxt = count + CW'(push) - CW'(pop);
  end

  // look_q: the predictor answer arriving this cycle belongs to a slot fetched by a
  // plain +4 advance, so it is live. Answers after a hold or redirect are stale.
  assign hit_now    = bus.f_predict_valid & look_q;
  assign hit        = pend_v | hit_now;
  assign hit_addr   = pend_v ? pend_a : bus.f_predict_addr;
  assign fetch_hold = bus.stall | fstall_q;

  always_ff @(posedge clk) begin
    if (push) begin
      q_pred[wr_ptr] <= dpt_q;
      q_tgt[wr_ptr]  <= bus.d_target_addr;
      q_ft[wr_ptr]   <= bus.d_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pc_q       <= RESET_PC;
      look_q     <= 1'b0;
      pend_v     <= 1'b0;
      pend_a     <= '0;
      dpt_q      <= 1'b0;
      fstall_q   <= 1'b0;
      miss_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      count    <= count_nxt;
      fstall_q <= (count_nxt >= HIGH_CNT);
      if (mispredict) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if ((push_req & q_full & ~pop) | (bus.x_resolve_valid & q_empty)) err_q <= 1'b1;
      if (mispredict && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;

      if (mispredict) begin
        pc_q   <= redirect_addr;
        pend_v <= 1'b0;
        look_q <= 1'b0;
        dpt_q  <= 1'b0;
      end else if (fetch_hold) begin
        // Park a live hit so it is not lost while fetch is frozen.
        if (hit_now && !pend_v) begin
          pend_v <= 1'b1;
          pend_a <= bus.f_predict_addr;
        end
        look_q <= 1'b0;
      end else begin
        dpt_q <= hit;
        if (hit) begin
          pc_q   <= hit_addr;
          pend_v <= 1'b0;
          look_q <= 1'b0;
        end else begin
          pc_q   <= pc_q + 32'd4;
          look_q <= 1'b1;
        end
      end
    end
  end

  assign bus.f_pc           = pc_q;
  assign bus.f_kill         = hit & ~mispredict;
  assign bus.d_pred_taken   = dpt_q;
  assign bus.fetch_stall    = fstall_q;
  assign bus.flush          = mispredict;
  assign bus.mispredict_cnt = miss_cnt_q;
  assign bus.q_error        = err_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random traffic, each cycle's expected
// outputs come from a queue-based reference model and are checked by a separate monitor.
module tb_fetch_pc_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int QDEPTH = 4;
  localparam int EW = 53;

  typedef struct packed {
    logic [31:0] pc;
    logic        kill;
    logic        dpt;
    logic        fstall;
    logic        flush;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] ft;
  } br_t;

  logic clk = 1'b0;
  logic rst_tb;
  always #5 clk = ~clk;

  fetch_pc_if bus();

  fetch_pc_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk   (clk),
    .reset (rst_tb),
    .bus   (bus)
  );

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  br_t         m_q[$];
  logic [31:0] m_pc;
  logic        m_fresh;
  logic        m_saved_v;
  logic [31:0] m_saved_a;
  logic        m_dec_taken;
  logic [15:0] m_miss;
  logic        m_err;

  task automatic model_reset();
    m_q.delete();
    m_pc        = RESET_PC;
    m_fresh     = 1'b0;
    m_saved_v   = 1'b0;
    m_saved_a   = '0;
    m_dec_taken = 1'b0;
    m_miss      = '0;
    m_err       = 1'b0;
  endtask

  task automatic idle();
    bus.stall           = 1'b0;
    bus.f_predict_valid = 1'b0;
    bus.f_predict_addr  = '0;
    bus.d_is_branch     = 1'b0;
    bus.d_pc            = '0;
    bus.d_target_addr   = '0;
    bus.x_resolve_valid = 1'b0;
    bus.x_taken         = 1'b0;
    bus.x_target        = '0;
  endtask

  // Called at posedge+1 with inputs already driven: predict this cycle, advance model.
  task automatic tick();
    exp_t        e;
    br_t         b;
    int          occ;
    logic        miss, live, frozen, resolving;
    logic [31:0] redir, next_tgt;
    if (rst_tb) begin
      model_reset();
      e = '{pc: RESET_PC, kill: 1'b0, dpt: 1'b0, fstall: 1'b0, flush: 1'b0, cnt: 16'd0, err: 1'b0};
      exp_q.push_back(e);
    end else begin
      occ       = m_q.size();
      resolving = bus.x_resolve_valid && occ > 0;
      miss      = 1'b0;
      redir     = '0;
      if (resolving) begin
        miss  = (bus.x_taken != m_q[0].taken) || (bus.x_taken && bus.x_target != m_q[0].target);
        redir = bus.x_taken ? bus.x_target : m_q[0].ft;
      end
      live     = m_saved_v || (bus.f_predict_valid && m_fresh);
      next_tgt = m_saved_v ? m_saved_a : bus.f_predict_addr;
      frozen   = bus.stall || (occ >= QDEPTH - 1);
      e = '{pc: m_pc, kill: live && !miss, dpt: m_dec_taken, fstall: occ >= QDEPTH - 1,
            flush: miss, cnt: m_miss, err: m_err};
      exp_q.push_back(e);

      if (bus.x_resolve_valid && occ == 0) m_err = 1'b1;
      if (miss) begin
        m_q.delete();
        if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
      end else begin
        if (resolving) void'(m_q.pop_front());
        if (bus.d_is_branch && !bus.stall) begin
          if (m_q.size() < QDEPTH) begin
            b.taken  = m_dec_taken;
            b.target = bus.d_target_addr;
            b.ft     = bus.d_pc + 32'd4;
            m_q.push_back(b);
          end else begin
            m_err = 1'b1;
          end
        end
      end

      if (miss) begin
        m_pc        = redir;
        m_saved_v   = 1'b0;
        m_fresh     = 1'b0;
        m_dec_taken = 1'b0;
      end else if (frozen) begin
        if (!m_saved_v && bus.f_predict_valid && m_fresh) begin
          m_saved_v = 1'b1;
          m_saved_a = bus.f_predict_addr;
        end
        m_fresh = 1'b0;
      end else begin
        m_dec_taken = live;
        if (live) begin
          m_pc      = next_tgt;
          m_saved_v = 1'b0;
          m_fresh   = 1'b0;
        end else begin
          m_pc    = m_pc + 32'd4;
          m_fresh = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_tb = 1'b1;
    idle();
    tick();
    tick();
    rst_tb = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected record per cycle, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("f_pc",           bus.f_pc,                  e.pc);
      chk("f_kill",         32'(bus.f_kill),           32'(e.kill));
      chk("d_pred_taken",   32'(bus.d_pred_taken),     32'(e.dpt));
      chk("fetch_stall",    32'(bus.fetch_stall),      32'(e.fstall));
      chk("flush",          32'(bus.flush),            32'(e.flush));
      chk("mispredict_cnt", 32'(bus.mispredict_cnt),   32'(e.cnt));
      chk("q_error",        32'(bus.q_error),          32'(e.err));
    end
  end

  initial begin
    rst_tb = 1'b1;
    idle();
    @(posedge clk);
    #1;
    repeat (3) tick();
    rst_tb = 1'b0;

    // Sequential fetch, then a predicted-taken branch at 0x10 that turns out not taken
    repeat (5) tick();
    bus.f_predict_valid = 1'b1;
    bus.f_predict_addr  = 32'h0000_0080;
    tick();
    idle();
    bus.d_is_branch   = 1'b1;
    bus.d_pc          = 32'h0000_0010;
    bus.d_target_addr = 32'h0000_0080;
    tick();
    idle();
    bus.x_resolve_valid = 1'b1;
    bus.x_taken         = 1'b0;
    tick();
    idle();
    repeat (2) tick();

    // Queue fills to the freeze threshold, one correct resolve, then overflow
    do_reset();
    bus.d_is_branch   = 1'b1;
    bus.d_pc          = 32'h0000_0100;
    bus.d_target_addr = 32'h0000_0300;
    repeat (3) tick();
    idle();
    repeat (2) tick();
    bus.x_resolve_valid = 1'b1;
    bus.x_taken         = m_q[0].taken;
    bus.x_target        = m_q[0].target;
    tick();
    idle();
    repeat (2) tick();
    bus.d_is_branch   = 1'b1;
    bus.d_pc          = 32'h0000_0200;
    bus.d_target_addr = 32'h0000_0400;
    repeat (3) tick();
    idle();
    tick();

    // Resolve against an empty queue: sticky error
    do_reset();
    bus.x_resolve_valid = 1'b1;
    bus.x_taken         = 1'b1;
    bus.x_target        = 32'h0000_0500;
    tick();
    idle();
    repeat (4) tick();

    // Reset while entries are queued and the pipeline is stalled
    do_reset();
    bus.d_is_branch   = 1'b1;
    bus.d_pc          = 32'h0000_0040;
    bus.d_target_addr = 32'h0000_0060;
    repeat (2) tick();
    idle();
    bus.stall = 1'b1;
    tick();
    rst_tb = 1'b1;
    tick();
    rst_tb    = 1'b0;
    bus.stall = 1'b0;
    repeat (2) tick();

    // Live hit arriving during a stall is kept until the stall lifts
    do_reset();
    repeat (3) tick();
    bus.f_predict_valid = 1'b1;
    bus.f_predict_addr  = 32'h0000_0200;
    bus.stall           = 1'b1;
    tick();
    bus.f_predict_valid = 1'b0;
    tick();
    bus.stall = 1'b0;
    tick();
    idle();
    repeat (2) tick();

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_tb              = ($urandom_range(0, 599) == 0);
      bus.stall           = ($urandom_range(0, 7) == 0);
      bus.f_predict_valid = ($urandom_range(0, 3) == 0);
      bus.f_predict_addr  = 32'($urandom_range(0, 1023)) << 2;
      bus.d_is_branch     = ($urandom_range(0, 2) == 0);
      bus.d_pc            = 32'($urandom_range(0, 1023)) << 2;
      bus.d_target_addr   = 32'($urandom_range(0, 1023)) << 2;
      bus.x_resolve_valid = ($urandom_range(0, 2) == 0);
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        bus.x_taken  = m_q[0].taken;
        bus.x_target = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1023)) << 2
                                                   : m_q[0].target;
      end else begin
        bus.x_taken  = 1'($urandom_range(0, 1));
        bus.x_target = 32'($urandom_range(0, 1023)) << 2;
      end
      tick();
    end
    rst_tb = 1'b0;
    idle();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
